// File: rtl/leiwand_gpio.sv
// leiwand_gpio: memory-mapped GPIO for the leiwand_rv32 native bus with direction
// control, synchronised inputs, atomic set/clear and edge-triggered interrupts.
module leiwand_gpio #(
    parameter int unsigned NR_GPIOS    = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    output logic                ready,
    input  logic [3:0]          wen,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    input  logic [NR_GPIOS-1:0] gpio_in,
    output logic [NR_GPIOS-1:0] gpio_out,
    output logic [NR_GPIOS-1:0] gpio_oe,
    output logic                irq
);

    localparam int unsigned N     = NR_GPIOS;
    localparam int unsigned CNT_W = 3;

    localparam logic [2:0] OFS_OUT      = 3'd0;
    localparam logic [2:0] OFS_DIR      = 3'd1;
    localparam logic [2:0] OFS_IN       = 3'd2;
    localparam logic [2:0] OFS_IRQ_EN   = 3'd3;
    localparam logic [2:0] OFS_IRQ_EDGE = 3'd4;
    localparam logic [2:0] OFS_IRQ_PEND = 3'd5;
    localparam logic [2:0] OFS_OUT_SET  = 3'd6;
    localparam logic [2:0] OFS_OUT_CLR  = 3'd7;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_fill_cnt;
    logic [CNT_W-1:0] w_fill_cnt_nxt;
    logic             w_armed;

    logic [N-1:0]     r_out;
    logic [N-1:0]     r_dir;
    logic [N-1:0]     r_irq_en;
    logic [N-1:0]     r_irq_edge;
    logic [N-1:0]     r_pend;
    logic [N-1:0]     r_prev;
    logic [N-1:0]     r_sync [SYNC_STAGES];
    logic             r_ready;
    logic [31:0]      r_rdata;

    logic             w_hit;
    logic             w_accept;
    logic             w_write;
    logic [2:0]       w_ofs;
    logic [31:0]      w_lane;
    logic [31:0]      w_wbits;
    logic [N-1:0]     w_lane_n;
    logic [N-1:0]     w_wbits_n;
    logic [N-1:0]     w_sync;
    logic [N-1:0]     w_rise;
    logic [N-1:0]     w_fall;
    logic [N-1:0]     w_pend_set;
    logic [N-1:0]     w_pend_clr;
    logic [N-1:0]     w_pend_nxt;
    logic [N-1:0]     w_out_nxt;
    logic [N-1:0]     w_dir_nxt;
    logic [N-1:0]     w_irq_en_nxt;
    logic [N-1:0]     w_irq_edge_nxt;
    logic [31:0]      w_rdata_mux;
    logic             w_unused;

    // Bus decode: a request is taken only while no acknowledge is in flight.
    assign w_hit     = valid && (addr[31:5] == BASE_ADDR[31:5]);
    assign w_accept  = w_hit && !r_ready;
    assign w_write   = w_accept && (wen != 4'b0000);
    assign w_ofs     = addr[4:2];
    assign w_lane    = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
    assign w_wbits   = wdata & w_lane;
    assign w_lane_n  = w_lane[N-1:0];
    assign w_wbits_n = w_wbits[N-1:0];
    assign w_unused  = ^{addr[1:0], wdata, w_lane, w_wbits};

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_prev;
    assign w_fall = ~w_sync & r_prev;

    // Arming FSM: hold off edge detection until synchroniser and prev hold real pin values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FILL;
            r_fill_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_fill_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fill_cnt_nxt = r_fill_cnt;
        w_armed        = 1'b0;
        case (r_state)
            S_FILL: begin
                if (r_fill_cnt == CNT_W'(SYNC_STAGES)) begin
                    w_state_nxt = S_ARMED;
                end else begin
                    w_fill_cnt_nxt = r_fill_cnt + CNT_W'(1);
                end
            end
            S_ARMED: begin
                w_armed = 1'b1;
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    // Register write path with byte-lane qualification.
    always_comb begin
        w_out_nxt      = r_out;
        w_dir_nxt      = r_dir;
        w_irq_en_nxt   = r_irq_en;
        w_irq_edge_nxt = r_irq_edge;
        w_pend_clr     = '0;
        if (w_write) begin
            case (w_ofs)
                OFS_OUT:      w_out_nxt      = (r_out & ~w_lane_n) | w_wbits_n;
                OFS_DIR:      w_dir_nxt      = (r_dir & ~w_lane_n) | w_wbits_n;
                OFS_IRQ_EN:   w_irq_en_nxt   = (r_irq_en & ~w_lane_n) | w_wbits_n;
                OFS_IRQ_EDGE: w_irq_edge_nxt = (r_irq_edge & ~w_lane_n) | w_wbits_n;
                OFS_IRQ_PEND: w_pend_clr     = w_wbits_n;
                OFS_OUT_SET:  w_out_nxt      = r_out | w_wbits_n;
                OFS_OUT_CLR:  w_out_nxt      = r_out & ~w_wbits_n;
                default:      w_out_nxt      = r_out;
            endcase
        end
    end

    // A new edge outranks a simultaneous write-1-to-clear.
    assign w_pend_set = w_armed ? ((w_rise & r_irq_edge) | (w_fall & ~r_irq_edge)) : '0;
    assign w_pend_nxt = (r_pend & ~w_pend_clr) | w_pend_set;

    always_comb begin
        w_rdata_mux = '0;
        case (w_ofs)
            OFS_OUT:      w_rdata_mux = 32'(r_out);
            OFS_DIR:      w_rdata_mux = 32'(r_dir);
            OFS_IN:       w_rdata_mux = 32'(w_sync);
            OFS_IRQ_EN:   w_rdata_mux = 32'(r_irq_en);
            OFS_IRQ_EDGE: w_rdata_mux = 32'(r_irq_edge);
            OFS_IRQ_PEND: w_rdata_mux = 32'(r_pend);
            default:      w_rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_accept;
            r_rdata <= w_accept ? w_rdata_mux : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out      <= '0;
            r_dir      <= '0;
            r_irq_en   <= '0;
            r_irq_edge <= '0;
            r_pend     <= '0;
        end else begin
            r_out      <= w_out_nxt;
            r_dir      <= w_dir_nxt;
            r_irq_en   <= w_irq_en_nxt;
            r_irq_edge <= w_irq_edge_nxt;
            r_pend     <= w_pend_nxt;
        end
    end

    // Input synchroniser chain followed by the one-cycle-delayed copy used for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= gpio_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync;
        end
    end

    assign ready    = r_ready;
    assign rdata    = r_rdata;
    assign gpio_out = r_out;
    assign gpio_oe  = r_dir;
    assign irq      = |(r_pend & r_irq_en);

endmodule

// File: tb/tb_leiwand_gpio.sv
// Self-checking bench for leiwand_gpio: directed scenarios plus random bus/pin traffic
// compared every cycle against a history-based reference model.
`timescale 1ns/1ps
module tb_leiwand_gpio;

    localparam int unsigned N    = 8;
    localparam int unsigned S    = 2;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          ready;
    logic [3:0]    wen;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [N-1:0]  gpio_in;
    logic [N-1:0]  gpio_out;
    logic [N-1:0]  gpio_oe;
    logic          irq;

    always #5 clk = ~clk;

    leiwand_gpio #(
        .NR_GPIOS    (N),
        .BASE_ADDR   (BASE),
        .SYNC_STAGES (S)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .ready    (ready),
        .wen      (wen),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: register contents plus the history of pin samples since reset.
    logic [N-1:0]  m_out, m_dir, m_en, m_edge, m_pend;
    logic          m_ready;
    logic          m_rd_chk;
    logic [31:0]   m_rdata;
    int            m_k;
    logic [N-1:0]  hist[$];

    // Pin value sampled at edge j after reset; before any sample, the synchroniser holds 0.
    function automatic logic [N-1:0] pin_at(input int j);
        if (j < 1 || j > hist.size()) return '0;
        return hist[j-1];
    endfunction

    task automatic tick();
        logic [31:0] lanes, bits, rd;
        logic [N-1:0] s, p, set, clr;
        int off;
        logic acc;
        if (rst) begin
            m_out = '0; m_dir = '0; m_en = '0; m_edge = '0; m_pend = '0;
            m_ready = 1'b0; m_rd_chk = 1'b0; m_rdata = '0;
            m_k = 0;
            hist.delete();
        end else begin
            m_k++;
            hist.push_back(gpio_in);
            set = '0;
            clr = '0;
            if (m_k >= int'(S) + 2) begin
                s = pin_at(m_k - int'(S));
                p = pin_at(m_k - int'(S) - 1);
                for (int i = 0; i < int'(N); i++)
                    if (s[i] != p[i] && s[i] == m_edge[i]) set[i] = 1'b1;
            end
            acc = valid && !m_ready && (addr >= BASE) && (addr < BASE + 32'd32);
            m_rd_chk = acc && (wen == 4'b0000);
            m_rdata  = '0;
            if (acc) begin
                off   = int'((addr - BASE) >> 2);
                lanes = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
                bits  = wdata & lanes;
                case (off)
                    0: rd = 32'(m_out);
                    1: rd = 32'(m_dir);
                    2: rd = 32'(pin_at(m_k - int'(S)));
                    3: rd = 32'(m_en);
                    4: rd = 32'(m_edge);
                    5: rd = 32'(m_pend);
                    default: rd = '0;
                endcase
                m_rdata = rd;
                if (wen != 4'b0000) begin
                    case (off)
                        0: m_out  = (m_out & ~N'(lanes)) | N'(bits);
                        1: m_dir  = (m_dir & ~N'(lanes)) | N'(bits);
                        3: m_en   = (m_en & ~N'(lanes)) | N'(bits);
                        4: m_edge = (m_edge & ~N'(lanes)) | N'(bits);
                        5: clr    = N'(bits);
                        6: m_out  = m_out | N'(bits);
                        7: m_out  = m_out & ~N'(bits);
                        default: ;
                    endcase
                end
            end
            m_pend  = (m_pend & ~clr) | set;
            m_ready = acc;
        end
        @(posedge clk);
        #1;
        chk("ready", 32'(ready), 32'(m_ready));
        chk("gpio_out", 32'(gpio_out), 32'(m_out));
        chk("gpio_oe", 32'(gpio_oe), 32'(m_dir));
        chk("irq", 32'(irq), 32'(|(m_pend & m_en)));
        if (!m_ready) chk("rdata_idle", rdata, 32'h0);
        else if (m_rd_chk) chk("rdata", rdata, m_rdata);
    endtask

    task automatic bus(input logic [4:0] ofs, input logic [3:0] we, input logic [31:0] d,
                       output logic [31:0] rd);
        valid = 1'b1;
        addr  = BASE + 32'(ofs);
        wen   = we;
        wdata = d;
        tick();
        rd    = rdata;
        valid = 1'b0;
        wen   = 4'b0000;
        tick();
    endtask

    logic [31:0] rd;
    int          cnt;

    initial begin
        rst = 1'b1; valid = 1'b0; wen = '0; addr = '0; wdata = '0;
        gpio_in = N'(1);
        m_out = '0; m_dir = '0; m_en = '0; m_edge = '0; m_pend = '0;
        m_ready = 1'b0; m_rd_chk = 1'b0; m_rdata = '0; m_k = 0;

        // Reset and FILL with pin 0 high throughout
        repeat (3) tick();
        chk("rst_out", 32'(gpio_out), 32'h0);
        chk("rst_dir", 32'(gpio_oe), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        rst = 1'b0;
        bus(5'h10, 4'hF, 32'h1, rd);
        bus(5'h0C, 4'hF, 32'h1, rd);
        tick();
        bus(5'h14, 4'h0, 32'h0, rd);
        chk("fill_pend", rd, 32'h0);
        chk("fill_irq", 32'(irq), 32'h0);

        // Read/write and access timing
        bus(5'h00, 4'hF, 32'hA5, rd);
        chk("out_a5", 32'(gpio_out), 32'hA5);
        bus(5'h00, 4'h0, 32'h0, rd);
        chk("rd_out", rd, 32'h0000_00A5);
        bus(5'h08, 4'hF, 32'hFF, rd);
        bus(5'h08, 4'h0, 32'h0, rd);
        chk("in_ro", rd, 32'(gpio_in));
        valid = 1'b1; addr = BASE + 32'h20; wen = 4'hF; wdata = 32'hFF;
        repeat (3) begin
            tick();
            chk("oow_ready", 32'(ready), 32'h0);
        end
        valid = 1'b0; wen = 4'h0;
        tick();
        chk("oow_out", 32'(gpio_out), 32'hA5);
        valid = 1'b1; addr = BASE; wen = 4'h0;
        cnt = 0;
        repeat (4) begin
            tick();
            if (ready) cnt++;
        end
        valid = 1'b0;
        tick();
        chk("held_pulses", 32'(cnt), 32'd2);

        // Atomic set/clear and byte lanes
        bus(5'h00, 4'hF, 32'h0F, rd);
        bus(5'h18, 4'hF, 32'hF0, rd);
        bus(5'h1C, 4'hF, 32'h03, rd);
        chk("atomic", 32'(gpio_out), 32'hFC);
        bus(5'h00, 4'b0010, 32'hFFFF_FFFF, rd);
        chk("lane1", 32'(gpio_out), 32'hFC);
        bus(5'h00, 4'b1110, 32'h0, rd);
        bus(5'h18, 4'b1110, 32'hFF, rd);
        chk("lane_excl", 32'(gpio_out), 32'hFC);
        bus(5'h00, 4'h0, 32'h0, rd);
        chk("rd_hi_zero", rd, 32'h0000_00FC);
        bus(5'h04, 4'b0001, 32'h1234_5678, rd);
        chk("dir_lane0", 32'(gpio_oe), 32'h78);

        // Edge interrupts: pin0 rising, pin1 falling
        bus(5'h0C, 4'hF, 32'h3, rd);
        bus(5'h10, 4'hF, 32'h1, rd);
        gpio_in = N'(2);
        repeat (S + 3) tick();
        bus(5'h14, 4'hF, 32'hFF, rd);
        chk("pre_irq", 32'(irq), 32'h0);
        gpio_in = N'(1);
        repeat (S) tick();
        chk("irq_early", 32'(irq), 32'h0);
        tick();
        chk("irq_on_time", 32'(irq), 32'h1);
        bus(5'h14, 4'h0, 32'h0, rd);
        chk("pend_03", rd, 32'h3);
        bus(5'h14, 4'hF, 32'h3, rd);
        gpio_in = N'(3);
        repeat (S + 3) tick();
        bus(5'h14, 4'h0, 32'h0, rd);
        chk("pin1_rise", rd, 32'h0);

        // W1C racing a fresh rising edge on pin0
        gpio_in = N'(2);
        repeat (S + 3) tick();
        gpio_in = N'(3);
        repeat (S + 3) tick();
        chk("race_pre", 32'(irq), 32'h1);
        gpio_in = N'(2);
        repeat (S + 3) tick();
        gpio_in = N'(3);
        repeat (S) tick();
        bus(5'h14, 4'hF, 32'h1, rd);
        chk("race_irq", 32'(irq), 32'h1);
        bus(5'h14, 4'h0, 32'h0, rd);
        chk("race_pend", rd, 32'h1);
        valid = 1'b1; addr = BASE + 32'h14; wen = 4'hF; wdata = 32'h1;
        tick();
        chk("w1c_irq", 32'(irq), 32'h0);
        valid = 1'b0; wen = 4'h0;
        tick();
        bus(5'h14, 4'h0, 32'h0, rd);
        chk("w1c_pend", rd, 32'h0);

        // Reset in the accept cycle of a write
        bus(5'h00, 4'hF, 32'h55, rd);
        valid = 1'b1; addr = BASE; wen = 4'hF; wdata = 32'hAA; rst = 1'b1;
        tick();
        chk("rstacc_ready", 32'(ready), 32'h0);
        rst = 1'b0; valid = 1'b0; wen = 4'h0;
        tick();
        chk("rstacc_ready2", 32'(ready), 32'h0);
        chk("rstacc_out", 32'(gpio_out), 32'h0);

        // Random bus and pin traffic
        for (int it = 0; it < 600; it++) begin
            int sel;
            if ($urandom_range(0, 3) == 0) gpio_in = N'($urandom);
            sel = int'($urandom_range(0, 11));
            if (sel < 8)       addr = BASE + 32'(sel) * 32'd4 + 32'($urandom_range(0, 3));
            else if (sel < 10) addr = BASE + 32'd32 + 32'($urandom_range(0, 63));
            else               addr = BASE - 32'd4;
            wen   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            wdata = $urandom;
            valid = 1'b1;
            rst   = ($urandom_range(0, 60) == 0);
            tick();
            rst = 1'b0; valid = 1'b0; wen = 4'h0;
            repeat ($urandom_range(1, 3)) tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
